// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / fetch controller.
// The fetch FSM states, the sequential PC increment and the default trap vector.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_WAIT       = 2'd1,
        S_WAIT_REDIR = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_STEP          = 4;
    localparam logic [8:0]  TRAP_VEC_DEFAULT = 9'h004;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: redirect, buffered redirect, hold, PC+4.
// With MISALIGN_TRAP_EN defined, misaligned redirect targets become TRAP_VEC.
module pc_next_sel
    import pc_fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = 9,
    parameter logic [PC_W-1:0] TRAP_VEC = PC_W'(TRAP_VEC_DEFAULT)
) (
    input  logic [PC_W-1:0] cur_pc,
    input  logic [PC_W-1:0] pend_pc,
    input  logic            pend_trap,
    input  logic            redir_pend,
    input  logic [31:0]     br_pc,
    input  logic            pc_sel,
    input  logic            stall,
    input  logic            fetch_done,
    input  logic            fetch_busy,
    output logic [PC_W-1:0] next_pc,
    output logic            next_trap,
    output logic [PC_W-1:0] br_target,
    output logic            br_trap
);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // Upper target bits are dropped by design; the PC is only PC_W wide.
    logic unused_br_hi;
    assign unused_br_hi = ^br_pc[31:PC_W];

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        br_target = {br_pc[PC_W-1:2], 2'b00};
        br_trap   = 1'b0;
        if (TRAP_EN && (br_pc[1:0] != 2'b00)) begin
            br_target = TRAP_VEC;
            br_trap   = 1'b1;
        end
    end

    // A live redirect only bypasses buffering when no fetch is left hanging.
    always_comb begin
        next_pc   = cur_pc;
        next_trap = 1'b0;
        if (pc_sel && !fetch_busy) begin
            next_pc   = br_target;
            next_trap = br_trap;
        end else if (redir_pend && fetch_done) begin
            next_pc   = pend_pc;
            next_trap = pend_trap;
        end else if (fetch_done && !stall) begin
            next_pc   = cur_pc + PC_W'(PC_STEP);
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, fetch-request FSM and redirect buffering/flush for the IF stage.
// Optional MISALIGN_TRAP_EN: misaligned redirects load TRAP_VEC and pulse misalign_trap.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = 9,
    parameter logic [PC_W-1:0] TRAP_VEC = PC_W'(TRAP_VEC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            stall,
    input  logic            imem_ready,
    output logic [PC_W-1:0] Cur_PC,
    output logic            imem_req,
    output logic            if_valid,
    output logic            flush,
    output logic            redirect_pend,
    output logic            misalign_trap
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pend_pc_q, next_pc, br_target;
    logic            req_q, pend_trap_q, trap_q, next_trap, br_trap;
    logic            fetch_done, fetch_busy;

    assign fetch_done = req_q & imem_ready;
    assign fetch_busy = req_q & ~imem_ready;

    pc_next_sel #(
        .PC_W     (PC_W),
        .TRAP_VEC (TRAP_VEC)
    ) u_next_sel (
        .cur_pc     (pc_q),
        .pend_pc    (pend_pc_q),
        .pend_trap  (pend_trap_q),
        .redir_pend (state_q == S_WAIT_REDIR),
        .br_pc      (BrPC),
        .pc_sel     (PcSel),
        .stall      (stall),
        .fetch_done (fetch_done),
        .fetch_busy (fetch_busy),
        .next_pc    (next_pc),
        .next_trap  (next_trap),
        .br_target  (br_target),
        .br_trap    (br_trap)
    );

    always_comb begin
        state_d = S_RUN;
        case (state_q)
            S_RUN, S_WAIT: begin
                if (fetch_busy) state_d = PcSel ? S_WAIT_REDIR : S_WAIT;
            end
            S_WAIT_REDIR: begin
                if (fetch_busy) state_d = S_WAIT_REDIR;
            end
            default: state_d = S_RUN;
        endcase
    end

    // Reset withdraws the request and drops any buffered redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RUN;
            pc_q        <= '0;
            req_q       <= 1'b0;
            pend_pc_q   <= '0;
            pend_trap_q <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            pc_q    <= next_pc;
            req_q   <= 1'b1;
            trap_q  <= next_trap;
            if (fetch_busy && PcSel) begin
                pend_pc_q   <= br_target;
                pend_trap_q <= br_trap;
            end
        end
    end

    assign Cur_PC        = pc_q;
    assign imem_req      = req_q;
    assign flush         = PcSel;
    assign redirect_pend = (state_q == S_WAIT_REDIR);
    assign if_valid      = fetch_done & ~stall & ~PcSel & (state_q != S_WAIT_REDIR);

`ifdef MISALIGN_TRAP_EN
    assign misalign_trap = trap_q;
`else
    logic unused_trap;
    assign unused_trap   = trap_q;
    assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: transaction-level model compared every cycle
// plus hand-computed literal expectations. Honours MISALIGN_TRAP_EN if defined.
module tb_pc_fetch_ctrl;

    localparam int PC_W = 9;

    logic            clk = 1'b0;
    logic            reset, PcSel, stall, imem_ready;
    logic [31:0]     BrPC;
    logic [PC_W-1:0] Cur_PC;
    logic            imem_req, if_valid, flush, redirect_pend, misalign_trap;

    int checks = 0;
    int errors = 0;

    pc_fetch_ctrl #(.PC_W(PC_W), .TRAP_VEC(9'h004)) dut (
        .clk           (clk),
        .reset         (reset),
        .PcSel         (PcSel),
        .BrPC          (BrPC),
        .stall         (stall),
        .imem_ready    (imem_ready),
        .Cur_PC        (Cur_PC),
        .imem_req      (imem_req),
        .if_valid      (if_valid),
        .flush         (flush),
        .redirect_pend (redirect_pend),
        .misalign_trap (misalign_trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Redirect target as seen from outside: low PC_W bits, trap vector if misaligned.
    function automatic logic [9:0] target_of(input logic [31:0] b);
        logic [9:0] r;
`ifdef MISALIGN_TRAP_EN
        if (b[1:0] != 2'b00) r = {1'b1, 9'h004};
        else                 r = {1'b0, b[8:0]};
`else
        r = {1'b0, b[8:0] & 9'h1FC};
`endif
        return r;
    endfunction

    // Model: PC, request-live flag, and an optional buffered redirect.
    int unsigned m_pc;
    bit          m_req, m_have_pend, m_pend_trap, m_trap, m_ok;
    int unsigned m_pend_pc;

    always @(posedge clk) begin
        automatic bit         done = m_req && imem_ready;
        automatic bit         busy = m_req && !imem_ready;
        automatic logic [9:0] t    = target_of(BrPC);
        if (reset) begin
            m_pc <= 0; m_req <= 0; m_have_pend <= 0; m_trap <= 0; m_ok <= 1;
        end else begin
            m_req  <= 1;
            m_trap <= 0;
            if (PcSel && !busy) begin
                m_pc <= t[8:0]; m_trap <= t[9];
            end else if (m_have_pend && done) begin
                m_pc <= m_pend_pc; m_trap <= m_pend_trap;
            end else if (done && !stall) begin
                m_pc <= (m_pc + 4) % 512;
            end
            if (busy && PcSel) begin
                m_pend_pc <= t[8:0]; m_pend_trap <= t[9];
            end
            m_have_pend <= busy && (PcSel || m_have_pend);
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("Cur_PC",        32'(Cur_PC),        32'(m_pc));
            check("imem_req",      32'(imem_req),      32'(m_req));
            check("if_valid",      32'(if_valid),
                  32'(m_req && imem_ready && !stall && !PcSel && !m_have_pend));
            check("flush",         32'(flush),         32'(PcSel));
            check("redirect_pend", 32'(redirect_pend), 32'(m_have_pend));
            check("misalign_trap", 32'(misalign_trap), 32'(m_trap));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic [31:0] br, input bit stl, input bit rdy);
        PcSel = sel; BrPC = br; stall = stl; imem_ready = rdy;
        #1;
    endtask

    initial begin
        m_ok = 0;
        reset = 1'b1;
        drive(0, 32'h0, 0, 0);
        tick(); tick();
        check("lit reset pc",  32'(Cur_PC),   32'h0);
        check("lit reset req", 32'(imem_req), 32'h0);
        check("lit reset pend", 32'(redirect_pend), 32'h0);

        reset = 1'b0;
        drive(0, 32'h0, 0, 1);
        tick();
        check("lit first req", 32'(imem_req), 32'h1);
        check("lit first valid", 32'(if_valid), 32'h1);
        check("lit pc 0", 32'(Cur_PC), 32'h0);
        tick(); check("lit pc 4",  32'(Cur_PC), 32'h4);
        tick(); check("lit pc 8",  32'(Cur_PC), 32'h8);
        tick(); check("lit pc 12", 32'(Cur_PC), 32'hC);
        tick(); check("lit pc 16", 32'(Cur_PC), 32'h10);

        // Redirect with fetch complete.
        drive(1, 32'h40, 0, 1);
        check("lit redir flush", 32'(flush),    32'h1);
        check("lit redir valid", 32'(if_valid), 32'h0);
        tick(); check("lit redir pc", 32'(Cur_PC), 32'h40);

        // Redirect buffered behind a stalled fetch.
        drive(1, 32'h80, 0, 0);
        tick(); check("lit buf hold", 32'(Cur_PC), 32'h40);
        check("lit buf pend", 32'(redirect_pend), 32'h1);
        drive(0, 32'h0, 0, 0);
        tick(); tick();
        drive(0, 32'h0, 0, 1);
        check("lit buf discard", 32'(if_valid), 32'h0);
        tick(); check("lit buf pc", 32'(Cur_PC), 32'h80);
        check("lit buf clear", 32'(redirect_pend), 32'h0);

        // Newest buffered redirect wins.
        drive(1, 32'h20, 0, 0); tick();
        drive(0, 32'h0, 0, 0);  tick();
        drive(1, 32'h60, 0, 0); tick();
        drive(0, 32'h0, 0, 1);  tick();
        check("lit newest wins", 32'(Cur_PC), 32'h60);

        // PcSel coinciding with ready while buffered: BrPC wins over pend.
        drive(1, 32'h24, 0, 0); tick();
        drive(1, 32'h28, 0, 1); tick();
        check("lit coincide", 32'(Cur_PC), 32'h28);

        // Redirect beats stall; stall alone holds.
        drive(1, 32'h30, 1, 1); tick();
        check("lit stall redir", 32'(Cur_PC), 32'h30);
        drive(0, 32'h0, 1, 1);
        check("lit stall valid", 32'(if_valid), 32'h0);
        tick(); check("lit stall hold", 32'(Cur_PC), 32'h30);

        // Wrap and truncation.
        drive(1, 32'h1FC, 0, 1); tick();
        drive(0, 32'h0, 0, 1);   tick();
        check("lit wrap", 32'(Cur_PC), 32'h0);
        drive(1, 32'hFFFF_FE10, 0, 1); tick();
        check("lit trunc", 32'(Cur_PC), 32'h10);

        // Misaligned redirect, direct then buffered.
        drive(1, 32'h42, 0, 1); tick();
`ifdef MISALIGN_TRAP_EN
        check("lit trap pc",    32'(Cur_PC),        32'h4);
        check("lit trap pulse", 32'(misalign_trap), 32'h1);
`else
        check("lit align pc",   32'(Cur_PC),        32'h40);
        check("lit no trap",    32'(misalign_trap), 32'h0);
`endif
        drive(0, 32'h0, 0, 1); tick();
        check("lit trap drop", 32'(misalign_trap), 32'h0);
        drive(1, 32'h93, 0, 0); tick();
        drive(0, 32'h0, 0, 1);  tick();
        tick();

        // Reset during a buffered wait drops everything.
        drive(1, 32'h100, 0, 0); tick();
        reset = 1'b1;
        drive(0, 32'h0, 0, 0); tick();
        check("lit mid reset pc",   32'(Cur_PC),        32'h0);
        check("lit mid reset pend", 32'(redirect_pend), 32'h0);
        check("lit mid reset req",  32'(imem_req),      32'h0);
        reset = 1'b0;
        drive(0, 32'h0, 0, 1);
        tick(); tick(); tick();
        check("lit after reset", 32'(Cur_PC), 32'h8);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
